// File: rtl/shft_arbiter.sv
// -----------------------------------------------------------------------------
// shft_arbiter
//
// Purpose:
//   Shares one shift unit between two requesters. Port 0 is the EX-stage ALU
//   path and port 1 is the multi-cycle multiply/divide unit. A round-robin
//   pointer picks the winner when both ports are eligible. Each port owns a
//   one-entry result buffer, so a stalled consumer on one port never blocks
//   the other port.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   reqN_valid/ready      request handshake for port N (ready == grant)
//   reqN_in               operand for port N
//   reqN_shiftword        [3:0] amount, [4] 1 = right, [5] arithmetic (right only)
//   respN_valid/ready     response handshake for port N (valid == buffer full)
//   respN_data            buffered shift result for port N
//   busy                  either response buffer holds a result
// -----------------------------------------------------------------------------
module shft_arbiter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [width-1:0] req0_in,
  input  logic [5:0]       req0_shiftword,
  output logic             req0_ready,
  output logic             resp0_valid,
  output logic [width-1:0] resp0_data,
  input  logic             resp0_ready,
  input  logic             req1_valid,
  input  logic [width-1:0] req1_in,
  input  logic [5:0]       req1_shiftword,
  output logic             req1_ready,
  output logic             resp1_valid,
  output logic [width-1:0] resp1_data,
  input  logic             resp1_ready,
  output logic             busy
);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e            slot0_q, slot0_d;
  slot_e            slot1_q, slot1_d;
  logic [width-1:0] data0_q, data0_d;
  logic [width-1:0] data1_q, data1_d;
  logic             prio_q, prio_d;

  logic             can0, can1;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic [width-1:0] shift_opnd;
  logic [5:0]       shift_word;
  logic [width-1:0] shift_res;

  // The single shared shifter: left when [4]=0, else logical or arithmetic right.
  function automatic logic [width-1:0] do_shift(input logic [width-1:0] x,
                                                 input logic [5:0]       sw);
    logic [width-1:0] r;
    if (!sw[4])
      r = x << sw[3:0];
    else if (sw[5])
      r = $signed(x) >>> sw[3:0];
    else
      r = x >> sw[3:0];
    return r;
  endfunction

  // Arbitration. A full slot can accept a new result only when its consumer
  // drains it in the same cycle. Reset masks eligibility so no request is
  // accepted while reset is held.
  always_comb begin
    can0   = (slot0_q == EMPTY) || resp0_ready;
    can1   = (slot1_q == EMPTY) || resp1_ready;
    elig0  = req0_valid && can0 && !reset;
    elig1  = req1_valid && can1 && !reset;
    grant0 = elig0 && (!elig1 || !prio_q);
    grant1 = elig1 && (!elig0 ||  prio_q);
  end

  // Only the granted payload is steered into the shifter.
  always_comb begin
    shift_opnd = grant1 ? req1_in        : req0_in;
    shift_word = grant1 ? req1_shiftword : req0_shiftword;
    shift_res  = do_shift(shift_opnd, shift_word);
  end

  // Slot next-state: a grant always (re)fills the slot, which covers the
  // back-to-back replace case; otherwise a drained full slot empties.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    prio_d  = prio_q;

    if (grant0) begin
      slot0_d = FULL;
      data0_d = shift_res;
    end else if ((slot0_q == FULL) && resp0_ready) begin
      slot0_d = EMPTY;
    end

    if (grant1) begin
      slot1_d = FULL;
      data1_d = shift_res;
    end else if ((slot1_q == FULL) && resp1_ready) begin
      slot1_d = EMPTY;
    end

    if (grant0)
      prio_d = 1'b1;
    else if (grant1)
      prio_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= EMPTY;
      slot1_q <= EMPTY;
      data0_q <= '0;
      data1_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      prio_q  <= prio_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = (slot0_q == FULL);
  assign resp1_valid = (slot1_q == FULL);
  assign resp0_data  = data0_q;
  assign resp1_data  = data1_q;
  assign busy        = (slot0_q == FULL) || (slot1_q == FULL);

endmodule

// File: tb/tb_shft_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shft_arbiter
//
// Purpose:
//   Directed self-checking bench for shft_arbiter. Inputs change 1 time unit
//   after each rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_shft_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_in, req1_in;
  logic [5:0]  req0_shiftword, req1_shiftword;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [15:0] resp0_data, resp1_data;
  logic        resp0_ready, resp1_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shft_arbiter #(.width(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_in        (req0_in),
    .req0_shiftword (req0_shiftword),
    .req0_ready     (req0_ready),
    .resp0_valid    (resp0_valid),
    .resp0_data     (resp0_data),
    .resp0_ready    (resp0_ready),
    .req1_valid     (req1_valid),
    .req1_in        (req1_in),
    .req1_shiftword (req1_shiftword),
    .req1_ready     (req1_ready),
    .resp1_valid    (resp1_valid),
    .resp1_data     (resp1_data),
    .resp1_ready    (resp1_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Drives every DUT input in one go.
  task automatic applyStimulus(input logic v0, input logic [15:0] in0,
                               input logic [5:0] sw0, input logic r0,
                               input logic v1, input logic [15:0] in1,
                               input logic [5:0] sw1, input logic r1);
    req0_valid     = v0;
    req0_in        = in0;
    req0_shiftword = sw0;
    resp0_ready    = r0;
    req1_valid     = v1;
    req1_in        = in1;
    req1_shiftword = sw1;
    resp1_ready    = r1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Moves to the sampling point of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  // Moves to the driving point of the next cycle.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  rsw  [4];
  logic [15:0] rexp [4];
  logic [15:0] prev;

  initial begin
    rsw[0] = 6'b010100; rexp[0] = 16'h0800;
    rsw[1] = 6'b110100; rexp[1] = 16'hF800;
    rsw[2] = 6'b111111; rexp[2] = 16'hFFFF;
    rsw[3] = 6'b110000; rexp[3] = 16'h8000;

    // ---------------- reset state ----------------
    reset = 1'b1;
    applyStimulus(0, 16'h0, 6'h0, 0, 0, 16'h0, 6'h0, 0);
    nextCycle();
    sample();
    checkOutput("rst_req0_ready",   {15'b0, req0_ready},  16'h0);
    checkOutput("rst_req1_ready",   {15'b0, req1_ready},  16'h0);
    checkOutput("rst_resp0_valid",  {15'b0, resp0_valid}, 16'h0);
    checkOutput("rst_resp1_valid",  {15'b0, resp1_valid}, 16'h0);
    checkOutput("rst_busy",         {15'b0, busy},        16'h0);
    checkOutput("rst_resp0_data",   resp0_data,           16'h0);
    checkOutput("rst_resp1_data",   resp1_data,           16'h0);
    nextCycle();
    reset = 1'b0;

    // ---------------- port 0 left shifts ----------------
    applyStimulus(1, 16'h8001, 6'b000100, 1, 0, 16'h0, 6'h0, 1);
    sample();
    checkOutput("p0_left_ready",  {15'b0, req0_ready}, 16'h1);
    checkOutput("p0_left_r1",     {15'b0, req1_ready}, 16'h0);
    nextCycle();
    applyStimulus(1, 16'h0001, 6'b100001, 1, 0, 16'h0, 6'h0, 1);
    sample();
    checkOutput("p0_left_valid",  {15'b0, resp0_valid}, 16'h1);
    checkOutput("p0_left_data",   resp0_data,           16'h0010);
    checkOutput("p0_left_busy",   {15'b0, busy},        16'h1);
    checkOutput("p0_b5_ready",    {15'b0, req0_ready},  16'h1);
    nextCycle();
    applyStimulus(0, 16'h0, 6'h0, 1, 0, 16'h0, 6'h0, 1);
    sample();
    checkOutput("p0_b5_data",     resp0_data, 16'h0002);
    nextCycle();
    sample();
    checkOutput("p0_drain_valid", {15'b0, resp0_valid}, 16'h0);
    checkOutput("p0_drain_busy",  {15'b0, busy},        16'h0);
    nextCycle();

    // ---------------- port 1 right shifts ----------------
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 16'h0, 6'h0, 1, 1, 16'h8000, rsw[k], 1);
      sample();
      checkOutput($sformatf("p1_right_ready%0d", k), {15'b0, req1_ready}, 16'h1);
      if (k > 0)
        checkOutput($sformatf("p1_right_data%0d", k - 1), resp1_data, rexp[k-1]);
      nextCycle();
    end
    applyStimulus(0, 16'h0, 6'h0, 1, 0, 16'h0, 6'h0, 1);
    sample();
    checkOutput("p1_right_data3", resp1_data, rexp[3]);
    nextCycle();

    // ---------------- alternating grants ----------------
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 16'(k + 1), 6'b000000, 1, 1, 16'(k + 16'h100), 6'b000001, 1);
      sample();
      checkOutput($sformatf("rr_g0_%0d", k), {15'b0, req0_ready}, (k % 2 == 0) ? 16'h1 : 16'h0);
      checkOutput($sformatf("rr_g1_%0d", k), {15'b0, req1_ready}, (k % 2 == 0) ? 16'h0 : 16'h1);
      checkOutput($sformatf("rr_excl_%0d", k), {15'b0, req0_ready & req1_ready}, 16'h0);
      if (k >= 2 && k % 2 == 0)
        checkOutput($sformatf("rr_d1_%0d", k), resp1_data, 16'((k - 1 + 16'h100) << 1));
      if (k >= 1 && k % 2 == 1)
        checkOutput($sformatf("rr_d0_%0d", k), resp0_data, 16'(k));
      nextCycle();
    end
    applyStimulus(0, 16'h0, 6'h0, 1, 0, 16'h0, 6'h0, 1);
    sample();
    checkOutput("rr_last_d0", resp0_data, 16'h0007);
    nextCycle();

    // ---------------- port 0 stalled ----------------
    applyStimulus(1, 16'h1234, 6'b000000, 1, 0, 16'h0, 6'h0, 1);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 16'hAAAA, 6'b000000, 0, 1, 16'h0003, 6'b000001, 1);
      sample();
      checkOutput($sformatf("stall_r0_%0d", k),   {15'b0, req0_ready},  16'h0);
      checkOutput($sformatf("stall_r1_%0d", k),   {15'b0, req1_ready},  16'h1);
      checkOutput($sformatf("stall_v0_%0d", k),   {15'b0, resp0_valid}, 16'h1);
      checkOutput($sformatf("stall_d0_%0d", k),   resp0_data,           16'h1234);
      nextCycle();
    end
    applyStimulus(1, 16'hAAAA, 6'b000000, 1, 1, 16'h0003, 6'b000001, 1);
    sample();
    checkOutput("unstall_r0", {15'b0, req0_ready}, 16'h1);
    checkOutput("unstall_r1", {15'b0, req1_ready}, 16'h0);
    checkOutput("unstall_d0", resp0_data,          16'h1234);
    nextCycle();
    applyStimulus(0, 16'h0, 6'h0, 0, 0, 16'h0, 6'h0, 0);
    sample();
    checkOutput("replace_v0", {15'b0, resp0_valid}, 16'h1);
    checkOutput("replace_d0", resp0_data,           16'hAAAA);
    checkOutput("stall_d1",   resp1_data,           16'h0006);
    nextCycle();
    applyStimulus(0, 16'h0, 6'h0, 1, 0, 16'h0, 6'h0, 1);
    nextCycle();

    // ---------------- single port streaming ----------------
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 16'h0001, 6'(k), 1, 0, 16'h0, 6'h0, 1);
      sample();
      checkOutput($sformatf("stream_ready%0d", k), {15'b0, req0_ready}, 16'h1);
      if (k > 0) begin
        prev = 16'h0001 << (k - 1);
        checkOutput($sformatf("stream_valid%0d", k - 1), {15'b0, resp0_valid}, 16'h1);
        checkOutput($sformatf("stream_data%0d", k - 1), resp0_data, prev);
      end
      nextCycle();
    end
    applyStimulus(0, 16'h0, 6'h0, 1, 0, 16'h0, 6'h0, 1);
    sample();
    checkOutput("stream_data7", resp0_data, 16'h0080);
    nextCycle();

    // ---------------- reset with both slots full ----------------
    applyStimulus(0, 16'h0, 6'h0, 1, 1, 16'h0005, 6'b000000, 0);
    nextCycle();
    applyStimulus(1, 16'h0009, 6'b000000, 0, 0, 16'h0, 6'h0, 0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1, 16'h0077, 6'b000000, 1, 1, 16'h0088, 6'b000000, 1);
    sample();
    checkOutput("rfull_v0",  {15'b0, resp0_valid}, 16'h1);
    checkOutput("rfull_v1",  {15'b0, resp1_valid}, 16'h1);
    checkOutput("rfull_r0",  {15'b0, req0_ready},  16'h0);
    checkOutput("rfull_r1",  {15'b0, req1_ready},  16'h0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 16'h0, 6'h0, 0, 0, 16'h0, 6'h0, 0);
    sample();
    checkOutput("rpost_v0",   {15'b0, resp0_valid}, 16'h0);
    checkOutput("rpost_v1",   {15'b0, resp1_valid}, 16'h0);
    checkOutput("rpost_busy", {15'b0, busy},        16'h0);
    checkOutput("rpost_d0",   resp0_data,           16'h0);
    nextCycle();
    applyStimulus(1, 16'h0001, 6'h0, 1, 1, 16'h0002, 6'h0, 1);
    sample();
    checkOutput("rpost_prio_r0", {15'b0, req0_ready}, 16'h1);
    checkOutput("rpost_prio_r1", {15'b0, req1_ready}, 16'h0);
    nextCycle();
    applyStimulus(0, 16'h0, 6'h0, 1, 0, 16'h0, 6'h0, 1);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shft_arbiter.md
# shft_arbiter

Round-robin arbiter and sequencer that shares one 16-bit shift unit between two requesters: port 0 is the EX-stage ALU path and port 1 is the multi-cycle multiply/divide unit. Each port has a valid/ready request channel and a valid/ready response channel. Each port also has a one-entry response buffer, so a stalled consumer never blocks the other port. The block sits in the execute stage beside the ALU and replaces direct instantiation of the shifter by either client.

## Interface

Parameters:
- width, 16, data width of shift operand and result.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has a shift request.
- req0_in  in  width  port 0 operand.
- req0_shiftword  in  6  port 0 control word: [3:0] amount, [4] direction (0 = left), [5] arithmetic when right.
- req0_ready  out  1  port 0 request accepted this cycle.
- resp0_valid  out  1  port 0 result buffer full.
- resp0_data  out  width  port 0 result.
- resp0_ready  in  1  port 0 consumer takes the result.
- req1_valid, req1_in, req1_shiftword, req1_ready, resp1_valid, resp1_data, resp1_ready: same as port 0, for port 1.
- busy  out  1  either response buffer full.

## Operation

Shift function is fixed and applied to the granted request:
- shiftword[4]=0: logical left by [3:0]. Bit 5 is ignored.
- [4]=1, [5]=0: logical right by [3:0].
- [4]=1, [5]=1: arithmetic right by [3:0], sign bit replicated.
- Amount range is 0-15. Amount 0 passes the operand unchanged. Result is truncated to width.

Slot state:
- Each port has a slot state, EMPTY or FULL.
- can_accept_i = slot_i EMPTY, or (slot_i FULL and resp_i_ready).

Arbitration:
- Each cycle, eligible_i = req_i_valid && can_accept_i.
- If only one port is eligible, it wins.
- If both are eligible, the port named by the priority pointer `prio` wins. prio=0 favours port 0.
- At most one grant per cycle.
- req_i_ready = grant_i. It is combinational from req valids, the slots, resp_i_ready and prio. It is never asserted when req_i_valid is low.
- On a grant to port i, prio is set to the other port (1-i). With no grant, prio holds.

Slot transitions for each port i, evaluated at the clock edge:
- EMPTY + grant_i -> FULL, resp_i_data <= shift result.
- FULL + resp_i_ready + grant_i -> FULL with the new data (back-to-back).
- FULL + resp_i_ready + no grant_i -> EMPTY, data holds.
- FULL + no resp_i_ready -> FULL, data holds. Port i cannot be granted.

Other rules:
- resp_i_valid = slot_i FULL.
- resp_i_data is stable while resp_i_valid is high and resp_i_ready is low.
- A requester must hold valid and its payload until ready. This is not checked; a request dropped before ready is simply not serviced.

## Timing

- Reset values: both slots EMPTY, resp0_valid=resp1_valid=0, resp0_data=resp1_data=0, prio=0, busy=0, req*_ready=0.
- reset asserted during operation clears any pending result in the next edge. A request presented in the reset cycle is not accepted (ready forced 0 while reset=1).
- Latency: request accepted at edge N, so resp_i_valid is high in the cycle after edge N, with data valid.
- Throughput: one shift per cycle in total. A single port that drains every cycle sustains one result per cycle.
- With both ports continuously valid and draining, grants alternate 0,1,0,1 starting from port 0 after reset.
- busy = resp0_valid || resp1_valid. It is registered-derived with no combinational input path.

## Test plan

- Reset, then port 0 only: req0_in=16'h8001, shiftword=6'b000100 -> req0_ready=1 the same cycle; next cycle resp0_valid=1, resp0_data=16'h0010. Bit 5 is ignored for left shifts: 6'b100001 on 16'h0001 -> 16'h0002.
- Right shifts on port 1 with 16'h8000: 6'b010100 -> 16'h0800; 6'b110100 -> 16'hF800; 6'b111111 -> 16'hFFFF. Amount 0 (6'b110000) -> 16'h8000.
- Both valid every cycle, both resp_ready=1, 6 cycles -> grants 0,1,0,1,0,1. prio returns to 0. No cycle has both req_ready high.
- Port 0 slot FULL with resp0_ready=0 held 4 cycles while req0 and req1 are valid -> req0_ready=0 throughout, port 1 granted every cycle, resp0_data unchanged. Then resp0_ready=1 -> port 0 granted that same cycle (back-to-back replace).
- Single port, resp_ready=1, 8 consecutive requests with amounts 0..7 on 16'h0001 -> 8 consecutive results 16'h0001..16'h0080, no bubbles.
- Reset asserted with both slots FULL and both requests valid -> next cycle resp0_valid=resp1_valid=0, busy=0, prio=0. No ready was asserted during the reset cycle.
